wb_port_arbiter: RTL and testbench

- Owns the single GPR write port. Shares it between the main pipeline writeback (after MEM/REEXE) and the long-latency multiply/divide unit (MDU).
- MDU results that lose arbitration park in a small FIFO. The main pipe has priority, limited by an anti-starvation counter that stalls it.
- Exports a pending-write bitmap so issue logic can interlock on parked results.
- Resolves WAW between parked MDU results and younger main-pipe writes.

---
 rtl/wb_port_arbiter_pkg.sv | 17 +
 rtl/wb_park_fifo.sv | 110 +++++++++++
 rtl/wb_port_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and defaults for the GPR write-port arbiter.
// Widths mirror the core-wide register-number and word sizes.
package wb_port_arbiter_pkg;

   localparam int GPR_NUM        = 5;
   localparam int SINGLE_WORD    = 32;
   localparam int PEND_W         = 32;
   localparam int STARVE_MAX_DEF = 3;

   typedef struct packed {
      logic                   valid;
      logic [GPR_NUM-1:0]     writeNum;
      logic [SINGLE_WORD-1:0] data;
      logic [SINGLE_WORD-1:0] pc;
   } wb_req_t;

endpackage

// File: rtl/wb_park_fifo.sv
// Parking FIFO for MDU results that lost the write port.
// Each entry carries a live bit so younger writes can kill it by dest.
module wb_park_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int GPR_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [GPR_W-1:0]  push_dest_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic [DATA_W-1:0] push_pc_i,
   input  logic              pop_i,
   input  logic              kill_i,
   input  logic [GPR_W-1:0]  kill_dest_i,
   output logic              empty_o,
   output logic              full_o,
   output logic              head_live_o,
   output logic              any_live_o,
   output logic [GPR_W-1:0]  head_dest_o,
   output logic [DATA_W-1:0] head_data_o,
   output logic [DATA_W-1:0] head_pc_o,
   output logic [PEND_W-1:0] pend_mask_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
   logic [PTR_W:0]    cnt_q, cnt_d;
   logic [DEPTH-1:0]  live_q, live_d;
   logic [GPR_W-1:0]  dest_q [DEPTH];
   logic [GPR_W-1:0]  dest_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [DATA_W-1:0] pc_q   [DEPTH];
   logic [DATA_W-1:0] pc_d   [DEPTH];

   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      live_d = live_q;
      dest_d = dest_q;
      data_d = data_q;
      pc_d   = pc_q;
      if (kill_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (dest_q[i] == kill_dest_i) live_d[i] = 1'b0;
         end
      end
      if (pop_i) begin
         live_d[rd_q] = 1'b0;
         rd_d         = rd_q + PTR_W'(1);
      end
      if (push_i) begin
         live_d[wr_q] = 1'b1;
         dest_d[wr_q] = push_dest_i;
         data_d[wr_q] = push_data_i;
         pc_d[wr_q]   = push_pc_i;
         wr_d         = wr_q + PTR_W'(1);
      end
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
         2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         live_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i] <= '0;
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         live_q <= live_d;
         dest_q <= dest_d;
         data_q <= data_d;
         pc_q   <= pc_d;
      end
   end

   always_comb begin
      pend_mask_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_q[i]) pend_mask_o[dest_q[i]] = 1'b1;
      end
      pend_mask_o[0] = 1'b0;
   end

   assign empty_o     = (cnt_q == '0);
   assign full_o      = (cnt_q == (PTR_W+1)'(DEPTH));
   assign head_live_o = !empty_o && live_q[rd_q];
   assign any_live_o  = |live_q;
   assign head_dest_o = dest_q[rd_q];
   assign head_data_o = data_q[rd_q];
   assign head_pc_o   = pc_q[rd_q];

endmodule

// File: rtl/wb_port_arbiter.sv
// Single GPR write port shared by main writeback and the MDU.
// Losing MDU results park in a FIFO; a starve counter bounds their wait.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int GPR_W      = GPR_NUM,
   parameter int DATA_W     = SINGLE_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              main_valid_i,
   input  logic [GPR_W-1:0]  main_writeNum_i,
   input  logic [DATA_W-1:0] main_data_i,
   input  logic [DATA_W-1:0] main_pc_i,
   output logic              main_allowin_o,
   input  logic              mdu_valid_i,
   input  logic [GPR_W-1:0]  mdu_writeNum_i,
   input  logic [DATA_W-1:0] mdu_data_i,
   input  logic [DATA_W-1:0] mdu_pc_i,
   output logic              mdu_ready_o,
   output logic              rf_wen_o,
   output logic [GPR_W-1:0]  rf_waddr_o,
   output logic [DATA_W-1:0] rf_wdata_o,
   output logic [DATA_W-1:0] debug_pc_o,
   output logic [31:0]       pend_mask_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   wb_req_t           main_req, mdu_req;
   logic [SW-1:0]     starve_q, starve_d;
   logic              f_empty, f_full, f_head_live, f_any_live;
   logic [GPR_W-1:0]  f_dest;
   logic [DATA_W-1:0] f_data, f_pc;
   logic [31:0]       f_pend;
   logic              main_wants, mdu_wants, force_grant, main_wr;
   logic              fifo_grant, bypass, mdu_fire, discard, push, pop;

   assign main_req = '{main_valid_i, main_writeNum_i, main_data_i, main_pc_i};
   assign mdu_req  = '{mdu_valid_i, mdu_writeNum_i, mdu_data_i, mdu_pc_i};

   always_comb begin
      main_wants  = main_req.valid && (main_req.writeNum != '0);
      mdu_wants   = mdu_req.valid && (mdu_req.writeNum != '0);
      force_grant = f_head_live && (starve_q == SW'(STARVE_MAX));
      main_wr     = main_wants && !force_grant;
      fifo_grant  = f_head_live && (force_grant || !main_wants);
      bypass      = f_empty && mdu_wants && !main_wants;
      mdu_fire    = mdu_req.valid && !f_full;
      discard     = mdu_fire && main_wr
                 && (mdu_req.writeNum == main_req.writeNum);
      push        = mdu_fire && mdu_wants && !bypass && !discard;
      // A dead head is dropped without using the port.
      pop         = fifo_grant || (!f_empty && !f_head_live);
   end

   always_comb begin
      starve_d = starve_q;
      if (fifo_grant || f_empty) starve_d = '0;
      else if (f_any_live && starve_q != SW'(STARVE_MAX))
         starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) starve_q <= '0;
      else      starve_q <= starve_d;
   end

   wb_park_fifo #(
      .DEPTH  (DEPTH),
      .GPR_W  (GPR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_dest_i (mdu_req.writeNum),
      .push_data_i (mdu_req.data),
      .push_pc_i   (mdu_req.pc),
      .pop_i       (pop),
      .kill_i      (main_wr),
      .kill_dest_i (main_req.writeNum),
      .empty_o     (f_empty),
      .full_o      (f_full),
      .head_live_o (f_head_live),
      .any_live_o  (f_any_live),
      .head_dest_o (f_dest),
      .head_data_o (f_data),
      .head_pc_o   (f_pc),
      .pend_mask_o (f_pend)
   );

   always_comb begin
      main_allowin_o = 1'b0;
      mdu_ready_o    = 1'b0;
      rf_wen_o       = 1'b0;
      rf_waddr_o     = '0;
      rf_wdata_o     = '0;
      debug_pc_o     = '0;
      pend_mask_o    = '0;
      if (rst) begin
         main_allowin_o = !force_grant;
         mdu_ready_o    = !f_full;
         pend_mask_o    = f_pend;
         unique case (1'b1)
            fifo_grant: begin
               rf_wen_o   = 1'b1;
               rf_waddr_o = f_dest;
               rf_wdata_o = f_data;
               debug_pc_o = f_pc;
            end
            main_wr: begin
               rf_wen_o   = 1'b1;
               rf_waddr_o = main_req.writeNum;
               rf_wdata_o = main_req.data;
               debug_pc_o = main_req.pc;
            end
            bypass: begin
               rf_wen_o   = 1'b1;
               rf_waddr_o = mdu_req.writeNum;
               rf_wdata_o = mdu_req.data;
               debug_pc_o = mdu_req.pc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: queue-based reference model plus directed scenarios
// followed by constrained-random traffic with occasional resets.
module tb_wb_port_arbiter;

   localparam int DEPTH = 2;
   localparam int SMAX  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        main_valid_i = 1'b0;
   logic [4:0]  main_writeNum_i = '0;
   logic [31:0] main_data_i = '0;
   logic [31:0] main_pc_i = '0;
   logic        main_allowin_o;
   logic        mdu_valid_i = 1'b0;
   logic [4:0]  mdu_writeNum_i = '0;
   logic [31:0] mdu_data_i = '0;
   logic [31:0] mdu_pc_i = '0;
   logic        mdu_ready_o;
   logic        rf_wen_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic [31:0] debug_pc_o;
   logic [31:0] pend_mask_o;

   always #5 clk = ~clk;

   wb_port_arbiter #(
      .DEPTH      (DEPTH),
      .STARVE_MAX (SMAX),
      .GPR_W      (5),
      .DATA_W     (32)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .main_valid_i    (main_valid_i),
      .main_writeNum_i (main_writeNum_i),
      .main_data_i     (main_data_i),
      .main_pc_i       (main_pc_i),
      .main_allowin_o  (main_allowin_o),
      .mdu_valid_i     (mdu_valid_i),
      .mdu_writeNum_i  (mdu_writeNum_i),
      .mdu_data_i      (mdu_data_i),
      .mdu_pc_i        (mdu_pc_i),
      .mdu_ready_o     (mdu_ready_o),
      .rf_wen_o        (rf_wen_o),
      .rf_waddr_o      (rf_waddr_o),
      .rf_wdata_o      (rf_wdata_o),
      .debug_pc_o      (debug_pc_o),
      .pend_mask_o     (pend_mask_o)
   );

   typedef struct {
      int          dest;
      logic [31:0] data;
      logic [31:0] pc;
      bit          live;
   } ent_t;

   ent_t q[$];
   int   starve = 0;
   int   tests = 0;
   int   fails = 0;

   logic        s_allow, s_ready, s_wen;
   logic [31:0] s_waddr, s_wdata, s_pc, s_pend;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   // One clock: drive, compare against the model, then advance the model.
   task automatic cycle(input bit r, input bit mv, input int mn,
                        input logic [31:0] md, input logic [31:0] mp,
                        input bit dv, input int dn,
                        input logic [31:0] dd, input logic [31:0] dp);
      bit          mw, dw, hl, frc, fire, anylive;
      int          src, sz;
      logic [31:0] e_addr, e_data, e_pc, e_pend;
      rst             = r;
      main_valid_i    = mv;
      main_writeNum_i = 5'(mn);
      main_data_i     = md;
      main_pc_i       = mp;
      mdu_valid_i     = dv;
      mdu_writeNum_i  = 5'(dn);
      mdu_data_i      = dd;
      mdu_pc_i        = dp;
      #1;
      s_allow = main_allowin_o;
      s_ready = mdu_ready_o;
      s_wen   = rf_wen_o;
      s_waddr = 32'(rf_waddr_o);
      s_wdata = rf_wdata_o;
      s_pc    = debug_pc_o;
      s_pend  = pend_mask_o;

      sz  = q.size();
      mw  = mv && mn != 0;
      dw  = dv && dn != 0;
      hl  = sz > 0 && q[0].live;
      frc = hl && starve == SMAX;
      if (frc)                 src = 2;
      else if (mw)             src = 1;
      else if (hl)             src = 2;
      else if (sz == 0 && dw)  src = 3;
      else                     src = 0;
      e_pend  = 0;
      anylive = 0;
      foreach (q[i]) if (q[i].live) begin
         e_pend[q[i].dest] = 1'b1;
         anylive = 1;
      end
      case (src)
         1: begin e_addr = mn; e_data = md; e_pc = mp; end
         2: begin e_addr = q[0].dest; e_data = q[0].data; e_pc = q[0].pc; end
         3: begin e_addr = dn; e_data = dd; e_pc = dp; end
         default: begin e_addr = 0; e_data = 0; e_pc = 0; end
      endcase

      if (!r) begin
         chk("m_allow", s_allow, 0);
         chk("m_ready", s_ready, 0);
         chk("m_wen", s_wen, 0);
         chk("m_waddr", s_waddr, 0);
         chk("m_wdata", s_wdata, 0);
         chk("m_pc", s_pc, 0);
         chk("m_pend", s_pend, 0);
      end else begin
         chk("m_allow", s_allow, 32'(!frc));
         chk("m_ready", s_ready, 32'(sz < DEPTH));
         chk("m_wen", s_wen, 32'(src != 0));
         chk("m_waddr", s_waddr, e_addr);
         chk("m_wdata", s_wdata, e_data);
         chk("m_pc", s_pc, e_pc);
         chk("m_pend", s_pend, e_pend);
      end

      @(posedge clk);
      if (!r) begin
         q.delete();
         starve = 0;
      end else begin
         fire = dv && (sz < DEPTH);
         if (src == 2 || sz == 0) starve = 0;
         else if (anylive && starve < SMAX) starve++;
         if (src == 1) foreach (q[i]) if (q[i].dest == mn) q[i].live = 0;
         if (src == 2 || (sz > 0 && !hl)) void'(q.pop_front());
         if (fire && dw && src != 3 && !(src == 1 && dn == mn))
            q.push_back('{dn, dd, dp, 1'b1});
      end
      @(negedge clk);
   endtask

   task automatic go(input bit mv, input int mn, input logic [31:0] md,
                     input bit dv, input int dn, input logic [31:0] dd);
      cycle(1, mv, mn, md, 32'h100 + 32'(mn * 4),
            dv, dn, dd, 32'h800 + 32'(dn * 4));
   endtask

   task automatic idle();
      go(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bit          hv;
      int          hn;
      logic [31:0] hd, hp;
      @(negedge clk);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_wen", s_wen, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

      go(0, 0, 0, 1, 7, 32'h11);
      chk("byp_wen", s_wen, 1);
      chk("byp_addr", s_waddr, 7);
      chk("byp_data", s_wdata, 32'h11);
      chk("byp_pend", s_pend, 0);

      go(1, 3, 32'h33, 1, 9, 32'h99);
      chk("col_addr", s_waddr, 3);
      chk("col_allow", s_allow, 1);
      idle();
      chk("col_pend", s_pend, 32'h200);
      chk("col_late", s_waddr, 9);
      idle();
      chk("col_clear", s_pend, 0);

      go(1, 1, 32'h1, 1, 9, 32'h9);
      for (int k = 2; k <= 4; k++) begin
         go(1, k, 32'(k), 0, 0, 0);
         chk("stv_allow", s_allow, 1);
      end
      go(1, 5, 32'h5, 0, 0, 0);
      chk("stv_force", s_allow, 0);
      chk("stv_addr", s_waddr, 9);
      go(1, 5, 32'h5, 0, 0, 0);
      chk("stv_after", s_waddr, 5);
      for (int k = 6; k <= 8; k++) go(1, k, 32'(k), 0, 0, 0);

      go(1, 1, 32'h1, 1, 4, 32'h44);
      go(1, 2, 32'h2, 1, 5, 32'h55);
      chk("bp_ready1", s_ready, 1);
      go(1, 3, 32'h3, 1, 6, 32'h66);
      chk("bp_full", s_ready, 0);
      chk("bp_pend", s_pend, 32'h30);
      idle();
      chk("bp_drain4", s_waddr, 4);
      idle();
      chk("bp_drain5", s_waddr, 5);
      idle();
      chk("bp_empty", s_wen, 0);

      go(1, 1, 32'h1, 1, 6, 32'hAA);
      go(1, 6, 32'hBB, 0, 0, 0);
      chk("waw_data", s_wdata, 32'hBB);
      chk("waw_pend", s_pend, 32'h40);
      idle();
      chk("waw_dead", s_wen, 0);
      chk("waw_pend0", s_pend, 0);
      idle();
      chk("waw_none", s_wen, 0);
      go(1, 6, 32'hBB, 1, 6, 32'hAA);
      chk("same_data", s_wdata, 32'hBB);
      chk("same_ready", s_ready, 1);
      idle();
      chk("same_none", s_wen, 0);
      chk("same_pend", s_pend, 0);

      go(1, 1, 32'h1, 1, 10, 32'hA0);
      go(1, 2, 32'h2, 1, 11, 32'hB0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rr_pend", s_pend, 0);
      chk("rr_wen", s_wen, 0);
      chk("rr_ready", s_ready, 0);
      idle();
      chk("rr_ready1", s_ready, 1);
      chk("rr_wen1", s_wen, 0);
      chk("rr_pend1", s_pend, 0);
      idle();
      chk("rr_wen2", s_wen, 0);

      hv = 0; hn = 0; hd = 0; hp = 0;
      for (int c = 0; c < 3000; c++) begin
         bit r;
         r = ($urandom_range(0, 199) != 0);
         if (!(hv && !s_allow && rst)) begin
            hv = ($urandom_range(0, 9) < 6);
            hn = $urandom_range(0, 6);
            hd = $urandom;
            hp = $urandom;
         end
         cycle(r, hv, hn, hd, hp,
               $urandom_range(0, 1) == 1, $urandom_range(0, 6),
               $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
